mux_scan_serializer: RTL and testbench

MUX_SCAN_SERIALIZER -- requirements
Module: mux_scan_serializer

---
 rtl/mux_scan_serializer.sv | 100 ++++++++++
 tb/tb_mux_scan_serializer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: serializes a 16-bit word LSB-first through an external 16:1 mux.
// Define MUX_SCAN_PARITY_EN to append an even-parity bit to every frame.
module mux_scan_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [15:0] mux_inp,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        ser_valid,
  output logic        ser_data,
  input  logic        ser_ready,
  output logic        ser_last,
  output logic        busy
);
`ifdef MUX_SCAN_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic acc_q, acc_d;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t      state_q, state_d;
  logic [15:0] inp_q, inp_d;
  logic [3:0]  sel_q, sel_d;
  assign mux_inp = inp_q;
  assign sel     = sel_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inp_q   <= 16'h0000;
      sel_q   <= 4'h0;
`ifdef MUX_SCAN_PARITY_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      inp_q   <= inp_d;
      sel_q   <= sel_d;
`ifdef MUX_SCAN_PARITY_EN
      acc_q   <= acc_d;
`endif
    end
  end
  always_comb begin
    state_d    = state_q;
    inp_d      = inp_q;
    sel_d      = sel_q;
`ifdef MUX_SCAN_PARITY_EN
    acc_d      = acc_q;
`endif
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    ser_last   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          inp_d   = load_data;
          sel_d   = 4'h0;
          state_d = SHIFT;
`ifdef MUX_SCAN_PARITY_EN
          acc_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_data  = mux_out;
`ifndef MUX_SCAN_PARITY_EN
        ser_last  = sel_q == 4'hF;
`endif
        if (ser_ready) begin
          // sel wraps 15 -> 0 naturally at the end of the data bits
          sel_d = sel_q + 4'h1;
`ifdef MUX_SCAN_PARITY_EN
          acc_d = acc_q ^ mux_out;
          if (sel_q == 4'hF) state_d = PARITY;
`else
          if (sel_q == 4'hF) state_d = IDLE;
`endif
        end
      end
`ifdef MUX_SCAN_PARITY_EN
      PARITY: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_data  = acc_q;
        ser_last  = 1'b1;
        if (ser_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer: directed and random frames checked against a bit-stream model.
module tb_mux_scan_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_ready;
  logic [15:0] mux_inp;
  logic [3:0]  sel;
  logic        mux_out;
  logic        ser_valid, ser_data, ser_last, busy;
  logic        ser_ready = 1'b0;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  // downstream 16:1 mux
  assign mux_out = mux_inp[sel];

  mux_scan_serializer dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .mux_inp(mux_inp), .sel(sel), .mux_out(mux_out),
    .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(ser_ready),
    .ser_last(ser_last), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, load_ready, 1);
    check({tag, "_valid"}, ser_valid, 0);
    check({tag, "_data"}, ser_data, 0);
    check({tag, "_last"}, ser_last, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Offers w, then follows the frame bit by bit against the expected stream.
  task automatic frame(input logic [15:0] w, input int stall_at, input int stall_len,
                       input bit hold, input bit inject, input int abort_at);
    logic exp_q[$];
    int n;
    for (int i = 0; i < 16; i++) exp_q.push_back(w[i]);
`ifdef MUX_SCAN_PARITY_EN
    exp_q.push_back(^w);
`endif
    n = exp_q.size();
    check("pre_ready", load_ready, 1);
    check("pre_busy", busy, 0);
    load_valid = 1'b1;
    load_data  = w;
    ser_ready  = 1'b1;
    @(posedge clk); #1;
    if (!hold) load_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("busy", busy, 1);
      check("ready_low", load_ready, 0);
      check("valid", ser_valid, 1);
      check("data", ser_data, exp_q[i]);
      check("last", ser_last, i == n - 1);
      check("mux_inp", mux_inp, w);
      if (i < 16) check("sel", sel, i);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_valid", ser_valid, 0);
        check("rst_sel", sel, 0);
        check("rst_inp", mux_inp, 0);
        check("rst_ready", load_ready, 1);
        load_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_hold_valid", ser_valid, 0);
        rst_n = 1'b1;
        return;
      end
      if (i == stall_at) begin
        ser_ready = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          if (i < 16) check("stall_sel", sel, i);
          check("stall_data", ser_data, exp_q[i]);
          check("stall_valid", ser_valid, 1);
        end
        ser_ready = 1'b1;
      end
      if (inject && i == 3) begin
        load_valid = 1'b1;
        load_data  = 16'h1234;
      end
      if (inject && i == 4) load_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("post_valid", ser_valid, 0);
    check("post_busy", busy, 0);
    check("post_ready", load_ready, 1);
  endtask

  initial begin
    #3;
    check_idle("reset");
    check("reset_sel", sel, 0);
    check("reset_inp", mux_inp, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("idle");
    frame(16'hA5C3, -1, 0, 0, 0, -1);
    frame(16'h0001, -1, 0, 0, 0, -1);
    frame(16'hFFFF, 5, 3, 0, 0, -1);
    frame(16'hF0F0, -1, 0, 0, 1, -1);
    frame(16'h5A5A, 9, 1, 0, 0, 9);
    check_idle("after_abort");
    frame(16'h8000, -1, 0, 0, 0, -1);
    frame(16'h1357, -1, 0, 1, 0, -1);
    frame(16'h2468, -1, 0, 1, 0, -1);
    frame(16'hC001, -1, 0, 0, 0, -1);
    repeat (8) begin
      logic [15:0] w;
      w = 16'($urandom);
      frame(w, $urandom_range(0, 16), $urandom_range(1, 4), 0, 0, -1);
    end
    @(posedge clk); #1;
    check_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
